// File: rtl/imem_loader_pkg.sv
// Shared encodings and sizes for the instruction-memory loader.
// Imported by the loader top and its byte packer.
package imem_loader_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int IMEM_ADDR_W    = 5;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_pack.sv
// Little-endian byte packer: lane byte_cnt receives each accepted byte.
// last_byte flags that the next accepted byte completes the word.
module imem_word_pack
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        last_byte
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [LANE_W-1:0] byte_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            word     <= '0;
        end else if (byte_en) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign last_byte = (byte_cnt == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory, one word per 4 bytes,
// and keeps the CPU held in reset until the whole image is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(2 ** ADDR_W);

    logic [1:0]        state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] waddr;
    logic              err_q;

    logic        can_start;
    logic        len_zero;
    logic        len_bad;
    logic        take;
    logic        xfer;
    logic        last_addr;
    logic        last_byte;
    logic [31:0] word;

    assign can_start = (state == IDLE) || (state == DONE);
    assign len_zero  = (load_len == '0);
    assign len_bad   = (load_len > DEPTH);
    assign take      = can_start && start && !len_zero && !len_bad;
    assign xfer      = byte_valid && (state == RECV);
    assign last_addr = ({1'b0, waddr} == (len - 1'b1));

    imem_word_pack u_pack (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (take),
        .byte_en   (xfer),
        .byte_data (byte_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            len   <= '0;
            waddr <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        unique case (1'b1)
                            len_zero: state <= DONE;
                            len_bad:  err_q <= 1'b1;
                            default: begin
                                len   <= load_len;
                                waddr <= '0;
                                state <= RECV;
                            end
                        endcase
                    end
                end
                RECV: begin
                    if (xfer && last_byte) state <= WRITE;
                end
                WRITE: begin
                    // Final address is held so fetch sees a stable end point.
                    if (last_addr) begin
                        state <= DONE;
                    end else begin
                        waddr <= waddr + 1'b1;
                        state <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign byte_ready = (state == RECV);
    assign mem_we     = (state == WRITE);
    assign busy       = (state == RECV) || (state == WRITE);
    assign done       = (state == DONE);
    assign cpu_hold   = (state != DONE);
    assign err        = err_q;
    assign mem_waddr  = waddr;
    assign mem_wdata  = word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
// Expected words are queued as bytes are sent and popped on mem_we.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  load_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int first_acc = 0;
    logic [36:0] sb[$];
    logic [36:0] sb_item;
    logic        prev_we = 1'b0;

    imem_loader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: addr %0d data %h, none expected",
                       mem_waddr, mem_wdata);
            end else begin
                sb_item = sb.pop_front();
                chk("write_addr", {27'd0, mem_waddr}, {27'd0, sb_item[36:32]});
                chk("write_data", mem_wdata, sb_item[31:0]);
            end
        end
        prev_we <= reset_n && mem_we;
    end

    task automatic do_start(input logic [5:0] len);
        start = 1'b1;
        load_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: byte_ready 0 expected 1");
        end
        accept_cyc = cyc;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [4:0] addr, input logic [31:0] w);
        sb.push_back({addr, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_waddr", {27'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cpu_hold", {31'd0, cpu_hold}, 32'd1);
            chk("idle_byte_ready", {31'd0, byte_ready}, 32'd0);
            chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        // Two words back-to-back
        sb.push_back({5'd0, 32'h0050_0013});
        sb.push_back({5'd1, 32'h0000_02B3});
        do_start(6'd2);
        chk("recv_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h13);
        first_acc = accept_cyc;
        send_byte(8'h00);
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'hB3);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid = 1'b0;
        chk("pre_done", {31'd0, done}, 32'd0);
        wait_done("done_two_words");
        chk("done_latency", cyc - first_acc, 32'd10);
        chk("done_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("sb_drained_1", sb.size(), 32'd0);

        // One word with stalls between bytes
        sb.push_back({5'd0, 32'hDEAD_BEEF});
        do_start(6'd1);
        chk("restart_done_drop", {31'd0, done}, 32'd0);
        chk("restart_hold", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = 32'hDEAD_BEEF;
            send_byte(w[8*i +: 8]);
            byte_valid = 1'b0;
            if (i < 3) begin
                repeat (3) begin
                    @(negedge clk);
                    chk("ready_in_gap", {31'd0, byte_ready}, 32'd1);
                end
            end
        end
        wait_done("done_gaps");
        chk("sb_drained_2", sb.size(), 32'd0);

        // Illegal length from IDLE, then a full-depth image
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(6'd33);
        chk("err_pulse", {31'd0, err}, 32'd1);
        chk("err_no_ready", {31'd0, byte_ready}, 32'd0);
        chk("err_hold", {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        chk("err_not_busy", {31'd0, busy}, 32'd0);
        chk("err_not_done", {31'd0, done}, 32'd0);
        do_start(6'd32);
        for (int a = 0; a < 32; a++) send_word(5'(a), $urandom);
        byte_valid = 1'b0;
        wait_done("done_full");
        chk("full_last_addr", {27'd0, mem_waddr}, 32'd31);
        chk("sb_drained_3", sb.size(), 32'd0);

        // Reset in the middle of word 3
        do_start(6'd4);
        send_word(5'd0, 32'h1111_2222);
        send_word(5'd1, 32'h3333_4444);
        send_word(5'd2, 32'h5555_6666);
        send_byte(8'hAA);
        send_byte(8'hBB);
        byte_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("mid_rst_waddr", {27'd0, mem_waddr}, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("sb_drained_4", sb.size(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_start(6'd1);
        send_word(5'd0, 32'h0700_0C01);
        byte_valid = 1'b0;
        wait_done("done_after_rst");

        // start in RECV is ignored; 0-length start in DONE keeps DONE
        sb.push_back({5'd0, 32'hA5A5_0001});
        sb.push_back({5'd1, 32'h5A5A_0002});
        do_start(6'd2);
        do_start(6'd1);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] img;
            img = {32'h5A5A_0002, 32'hA5A5_0001};
            send_byte(img[8*i +: 8]);
        end
        byte_valid = 1'b0;
        wait_done("done_ignore_start");
        chk("ignore_last_addr", {27'd0, mem_waddr}, 32'd1);
        chk("sb_drained_5", sb.size(), 32'd0);
        do_start(6'd0);
        chk("zero_len_done", {31'd0, done}, 32'd1);
        chk("zero_len_hold", {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        chk("zero_len_done2", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        chk("sb_final", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
